rr_audio_mixer: RTL and testbench

RR_AUDIO_MIXER -- requirements
Module: rr_audio_mixer

---
 rtl/rr_audio_pkg.sv | 20 ++
 rtl/rr_fade_ctrl.sv | 84 ++++++++
 rtl/rr_audio_mixer.sv | 67 ++++++
 tb/tb_rr_audio_mixer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_audio_pkg.sv
// Shared types and constants for the round-robin audio mixer.
// The fade FSM states, gain ceiling and default carrier width live here.
package rr_audio_pkg;

  typedef enum logic [1:0] {
    MUTED    = 2'd0,
    FADE_IN  = 2'd1,
    PLAYING  = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_t;

  localparam int GAIN_W           = 4;
  localparam int GAIN_MAX         = 15;
  localparam int PWM_BITS_DEFAULT = 8;
  localparam int NUM_CH           = 2;
  localparam int VOL_W            = 4;
  localparam int SUM_W            = 5;
  localparam int LEVEL_W          = 9;

endpackage

// File: rtl/rr_fade_ctrl.sv
// Master-gain fade controller: four-state FSM, fade prescaler and gain register.
// The gain ramps one step per FADE_DIV cycles toward the level implied by enabled.
module rr_fade_ctrl
  import rr_audio_pkg::*;
#(
  parameter int FADE_DIV = 65536
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enabled,
  output logic [GAIN_W-1:0] g,
  output logic              muted
);

  localparam int PRES_W = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRES_W-1:0] PRES_LAST = PRES_W'(FADE_DIV - 1);
  localparam logic [PRES_W-1:0] PRES_ONE  = PRES_W'(1);
  localparam logic [GAIN_W-1:0] G_MAX     = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] G_ONE     = GAIN_W'(1);

  fade_state_t       state_reg, state_next;
  logic [GAIN_W-1:0] g_reg, g_next;
  logic [PRES_W-1:0] pres_reg, pres_next;
  logic              muted_reg;
  logic              tick;

  assign tick  = (pres_reg == PRES_LAST);
  assign g     = g_reg;
  assign muted = muted_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= MUTED;
      g_reg     <= '0;
      pres_reg  <= '0;
      muted_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      pres_reg  <= pres_next;
      muted_reg <= (state_reg == MUTED);
    end
  end

  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    pres_next  = tick ? '0 : pres_reg + PRES_ONE;
    case (state_reg)
      MUTED: begin
        g_next = '0;
        if (enabled) state_next = FADE_IN;
      end
      FADE_IN: begin
        // A change of request beats a coincident tick: gain holds this cycle.
        if (!enabled) begin
          state_next = FADE_OUT;
        end else if (tick) begin
          if (g_reg < G_MAX) g_next = g_reg + G_ONE;
          if (g_reg >= G_MAX - G_ONE) state_next = PLAYING;
        end
      end
      PLAYING: begin
        g_next = G_MAX;
        if (!enabled) state_next = FADE_OUT;
      end
      FADE_OUT: begin
        if (enabled) begin
          state_next = FADE_IN;
        end else if (tick) begin
          if (g_reg != '0) g_next = g_reg - G_ONE;
          if (g_reg <= G_ONE) state_next = MUTED;
        end
      end
      default: begin
        state_next = MUTED;
        g_next     = '0;
      end
    endcase
    // Restart the step interval on every state change.
    if (state_next != state_reg) pres_next = '0;
  end

endmodule

// File: rtl/rr_audio_mixer.sv
// Two-channel square-wave mixer with master-gain fades and a PWM output stage.
// The PWM level is captured once per carrier period so it never changes mid-pulse.
module rr_audio_mixer
  import rr_audio_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT,
  parameter int FADE_DIV = 65536
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enabled,
  input  logic             speaker_b,
  input  logic             speaker_m,
  input  logic [VOL_W-1:0] vol_b,
  input  logic [VOL_W-1:0] vol_m,
  output logic             audio_pwm,
  output logic             muted
);

  localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

  logic [NUM_CH-1:0]             spk_q_reg;
  logic [NUM_CH-1:0][VOL_W-1:0]  vol_q_reg;
  logic [NUM_CH-1:0][SUM_W-1:0]  amp;
  logic [SUM_W-1:0]              sum;
  logic [GAIN_W-1:0]             gain;
  logic [PWM_BITS-1:0]           level_next;
  logic [PWM_BITS-1:0]           cnt_reg;
  logic [PWM_BITS-1:0]           level_q_reg;
  logic                          audio_pwm_reg;

  rr_fade_ctrl #(
    .FADE_DIV (FADE_DIV)
  ) u_fade (
    .clock   (clock),
    .reset   (reset),
    .enabled (enabled),
    .g       (gain),
    .muted   (muted)
  );

  // Channel 0 is bass, channel 1 is melody.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign amp[gi] = spk_q_reg[gi] ? {1'b0, vol_q_reg[gi]} : '0;
  end

  assign sum        = amp[0] + amp[1];
  assign level_next = PWM_BITS'((LEVEL_W'(sum) * LEVEL_W'(gain)) >> 1);
  assign audio_pwm  = audio_pwm_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      spk_q_reg     <= '0;
      vol_q_reg     <= '0;
      cnt_reg       <= '0;
      level_q_reg   <= '0;
      audio_pwm_reg <= 1'b0;
    end else begin
      spk_q_reg     <= {speaker_m, speaker_b};
      vol_q_reg     <= {vol_m, vol_b};
      cnt_reg       <= cnt_reg + CNT_ONE;
      if (cnt_reg == '0) level_q_reg <= level_next;
      audio_pwm_reg <= (cnt_reg < level_q_reg);
    end
  end

endmodule

// File: tb/tb_rr_audio_mixer.sv
// Self-checking bench for rr_audio_mixer with FADE_DIV = 4, PWM_BITS = 8.
// Expected gains, levels and duty counts come from closed-form arithmetic on elapsed cycles.
module tb_rr_audio_mixer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enabled = 1'b0;
  logic       speaker_b = 1'b0;
  logic       speaker_m = 1'b0;
  logic [3:0] vol_b = 4'd0;
  logic [3:0] vol_m = 4'd0;
  logic       audio_pwm;
  logic       muted;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  rr_audio_mixer #(
    .PWM_BITS (8),
    .FADE_DIV (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enabled   (enabled),
    .speaker_b (speaker_b),
    .speaker_m (speaker_m),
    .vol_b     (vol_b),
    .vol_m     (vol_m),
    .audio_pwm (audio_pwm),
    .muted     (muted)
  );

  always #5 clock = ~clock;

  // Carrier phase: counts cycles since reset modulo 256.
  always @(posedge clock) begin
    if (reset) exp_cnt <= 0;
    else       exp_cnt <= (exp_cnt + 1) % 256;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic int exp_level(input int sb, input int sm, input int vb, input int vm, input int g);
    return (((sb != 0 ? vb : 0) + (sm != 0 ? vm : 0)) * g) / 2;
  endfunction

  function automatic int ramp_up(input int k);
    return (k / 4 > 15) ? 15 : k / 4;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    enabled = 1'b0;
    cyc(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enabled = 1'b0;
    cyc(3);
    checks++; if (muted !== 1'b1) begin errors++; $display("FAIL reset_muted actual=%b required=1", muted); end
    checks++; if (audio_pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm actual=%b required=0", audio_pwm); end
    checks++; if (dut.gain !== 4'd0) begin errors++; $display("FAIL reset_gain actual=%0d required=0", dut.gain); end
    checks++; if (dut.level_q_reg !== 8'd0) begin errors++; $display("FAIL reset_level actual=%0d required=0", dut.level_q_reg); end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_silence();
    int hi = 0;
    int unmuted = 0;
    speaker_b = 1'b1; speaker_m = 1'b1; vol_b = 4'd15; vol_m = 4'd15;
    for (int i = 0; i < 2000; i++) begin
      cyc(1);
      if (audio_pwm !== 1'b0) hi++;
      if (muted !== 1'b1) unmuted++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL silence_pwm high_cycles actual=%0d required=0", hi); end
    checks++; if (unmuted != 0) begin errors++; $display("FAIL silence_muted low_cycles actual=%0d required=0", unmuted); end
    $display("test_silence done: 2000 cycles");
  endtask

  task automatic test_fade_in();
    logic [3:0] eg;
    enabled = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      cyc(1);
      eg = 4'(ramp_up(k));
      checks++; if (dut.gain !== eg) begin errors++; $display("FAIL fade_in_gain k=%0d actual=%0d required=%0d", k, dut.gain, eg); end
      if (k == 0) begin
        checks++; if (muted !== 1'b1) begin errors++; $display("FAIL fade_in_muted_k0 actual=%b required=1", muted); end
      end
      if (k == 1) begin
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL fade_in_muted_k1 actual=%b required=0", muted); end
      end
    end
    $display("test_fade_in done: gain=%0d", dut.gain);
  endtask

  task automatic test_level();
    int sb, sm, vb, vm, lvl, hi;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin sb = 1; sm = 0; vb = 15; vm = 0; end
      else if (c == 1) begin sb = 1; sm = 1; vb = 15; vm = 15; end
      else begin
        sb = int'($urandom_range(0, 1)); sm = int'($urandom_range(0, 1));
        vb = int'($urandom_range(0, 15)); vm = int'($urandom_range(0, 15));
      end
      speaker_b = sb[0]; speaker_m = sm[0]; vol_b = 4'(vb); vol_m = 4'(vm);
      lvl = exp_level(sb, sm, vb, vm, 15);
      cyc(600);
      checks++; if (dut.level_q_reg !== 8'(lvl)) begin errors++; $display("FAIL level_q case=%0d actual=%0d required=%0d", c, dut.level_q_reg, lvl); end
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        cyc(1);
        if (audio_pwm === 1'b1) hi++;
      end
      checks++; if (hi != lvl) begin errors++; $display("FAIL duty case=%0d actual=%0d required=%0d", c, hi, lvl); end
      $display("test_level case=%0d sb=%0d sm=%0d vb=%0d vm=%0d level=%0d high=%0d", c, sb, sm, vb, vm, lvl, hi);
    end
  endtask

  task automatic test_mid_period();
    int hi = 0;
    int stale = 0;
    bit found = 0;
    speaker_b = 1'b1; speaker_m = 1'b1; vol_b = 4'd15; vol_m = 4'd15;
    cyc(600);
    for (int i = 0; i < 300 && !found; i++) begin
      cyc(1);
      if (exp_cnt == 100) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_sync actual=not_found required=cnt100"); end
    vol_b = 4'd4; vol_m = 4'd0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc(1);
      if (exp_cnt == 1) found = 1;
      else begin
        if (audio_pwm === 1'b1) hi++;
        if (dut.level_q_reg !== 8'd225) stale++;
      end
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_level_hold changed_cycles actual=%0d required=0", stale); end
    checks++; if (hi != 125) begin errors++; $display("FAIL mid_rest_of_period high actual=%0d required=125", hi); end
    checks++; if (dut.level_q_reg !== 8'd30) begin errors++; $display("FAIL mid_new_level actual=%0d required=30", dut.level_q_reg); end
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      if (audio_pwm === 1'b1) hi++;
    end
    checks++; if (hi != 30) begin errors++; $display("FAIL mid_next_period high actual=%0d required=30", hi); end
    $display("test_mid_period done: next period high=%0d", hi);
  endtask

  task automatic test_fade_out(input int n);
    logic [3:0] eg;
    int v;
    do_reset();
    enabled = 1'b1;
    cyc(4 * n + 1);
    checks++; if (dut.gain !== 4'(n)) begin errors++; $display("FAIL fade_out_start n=%0d actual=%0d required=%0d", n, dut.gain, n); end
    enabled = 1'b0;
    for (int j = 0; j <= 4 * n + 1; j++) begin
      cyc(1);
      v = n - j / 4;
      eg = 4'(v < 0 ? 0 : v);
      checks++; if (dut.gain !== eg) begin errors++; $display("FAIL fade_out_gain n=%0d j=%0d actual=%0d required=%0d", n, j, dut.gain, eg); end
      if (j == 4 * n) begin
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL fade_out_muted_early n=%0d actual=%b required=0", n, muted); end
      end
      if (j == 4 * n + 1) begin
        checks++; if (muted !== 1'b1) begin errors++; $display("FAIL fade_out_muted n=%0d actual=%b required=1", n, muted); end
      end
    end
    $display("test_fade_out n=%0d done: gain=%0d muted=%b", n, dut.gain, muted);
  endtask

  task automatic test_back_to_back();
    do_reset();
    enabled = 1'b1;
    cyc(8);
    enabled = 1'b0;
    cyc(1);
    checks++; if (dut.gain !== 4'd1) begin errors++; $display("FAIL b2b_transition_wins actual=%0d required=1", dut.gain); end
    enabled = 1'b1;
    cyc(1);
    checks++; if (dut.gain !== 4'd1) begin errors++; $display("FAIL b2b_reenter actual=%0d required=1", dut.gain); end
    checks++; if (muted !== 1'b0) begin errors++; $display("FAIL b2b_muted actual=%b required=0", muted); end
    cyc(3);
    checks++; if (dut.gain !== 4'd1) begin errors++; $display("FAIL b2b_hold actual=%0d required=1", dut.gain); end
    cyc(1);
    checks++; if (dut.gain !== 4'd2) begin errors++; $display("FAIL b2b_step actual=%0d required=2", dut.gain); end
    $display("test_back_to_back done: gain=%0d", dut.gain);
  endtask

  task automatic test_reset_mid_fade();
    int hi = 0;
    do_reset();
    speaker_b = 1'b1; speaker_m = 1'b1; vol_b = 4'd15; vol_m = 4'd15;
    enabled = 1'b1;
    cyc(61);
    enabled = 1'b0;
    cyc(33);
    checks++; if (dut.gain !== 4'd7) begin errors++; $display("FAIL rst_mid_gain actual=%0d required=7", dut.gain); end
    reset = 1'b1;
    cyc(1);
    checks++; if (muted !== 1'b1) begin errors++; $display("FAIL rst_mid_muted actual=%b required=1", muted); end
    checks++; if (audio_pwm !== 1'b0) begin errors++; $display("FAIL rst_mid_pwm actual=%b required=0", audio_pwm); end
    checks++; if (dut.gain !== 4'd0) begin errors++; $display("FAIL rst_mid_gain0 actual=%0d required=0", dut.gain); end
    checks++; if (dut.level_q_reg !== 8'd0) begin errors++; $display("FAIL rst_mid_level actual=%0d required=0", dut.level_q_reg); end
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (audio_pwm !== 1'b0) hi++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL rst_mid_no_pulse high actual=%0d required=0", hi); end
    $display("test_reset_mid_fade done");
  endtask

  initial begin
    test_reset();
    test_silence();
    test_fade_in();
    test_level();
    test_mid_period();
    test_fade_out(9);
    test_fade_out(int'($urandom_range(1, 14)));
    test_back_to_back();
    test_reset_mid_fade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
